// File: rtl/regfile_sb_pkg.sv
// Shared processor definitions for the scoreboarded register file:
// default widths, the register-index type and the per-register state.
package regfile_sb_pkg;

  localparam int unsigned DEF_DATA_W = 16;
  localparam int unsigned DEF_ADDR_W = 3;

  // Widest register address the processor family uses; narrower files
  // zero-extend their addresses into this index type for comparisons.
  localparam int unsigned MAX_ADDR_W = 8;

  typedef logic [MAX_ADDR_W-1:0] reg_idx_t;

  // Scoreboard state of one architectural register.
  typedef enum logic {
    FREE = 1'b0,
    PEND = 1'b1
  } reg_state_e;

  function automatic logic is_r0(input reg_idx_t idx);
    return idx == '0;
  endfunction

endpackage

// File: rtl/regfile_sb_if.sv
// Bus bundle between an issue/writeback stage (master) and the
// scoreboarded register file (slave).
interface regfile_sb_if
  import regfile_sb_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned NREAD  = 2
);

  logic                      we;
  logic [ADDR_W-1:0]         waddr;
  logic [DATA_W-1:0]         wdata;
  logic [NREAD*ADDR_W-1:0]   raddr;
  logic [NREAD*DATA_W-1:0]   rdata;
  logic [NREAD-1:0]          rvalid;
  logic                      alloc_en;
  logic [ADDR_W-1:0]         alloc_addr;
  logic                      alloc_ok;
  logic [(2**ADDR_W)-1:0]    pending;

  modport master (
    output we, waddr, wdata, raddr, alloc_en, alloc_addr,
    input  rdata, rvalid, alloc_ok, pending
  );

  modport slave (
    input  we, waddr, wdata, raddr, alloc_en, alloc_addr,
    output rdata, rvalid, alloc_ok, pending
  );

endinterface

// File: rtl/regfile_sb_read.sv
// One combinational read port: r0 zero mux, same-cycle write forwarding
// and the valid flag derived from the scoreboard.
module regfile_sb_read
  import regfile_sb_pkg::*;
#(
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter int unsigned ADDR_W  = DEF_ADDR_W,
  parameter int unsigned BYPASS  = 1,
  parameter int unsigned ZERO_R0 = 1
) (
  input  logic [ADDR_W-1:0] raddr_i,
  input  logic [DATA_W-1:0] stored_i,
  input  logic              stored_pend_i,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic              rvalid_o
);

  // Priority: hardwired zero, then forwarded write data, then stored value.
  // wr_en_i already excludes discarded r0 writes.
  always_comb begin
    rdata_o  = stored_i;
    rvalid_o = ~stored_pend_i;
    if ((ZERO_R0 != 0) && is_r0(reg_idx_t'(raddr_i))) begin
      rdata_o  = '0;
      rvalid_o = 1'b1;
    end else if ((BYPASS != 0) && wr_en_i && (waddr_i == raddr_i)) begin
      rdata_o  = wdata_i;
      rvalid_o = 1'b1;
    end
  end

endmodule

// File: rtl/regfile_sb.sv
// Register file with one write port, NREAD combinational read ports and a
// per-register pending scoreboard for multi-cycle operations.
module regfile_sb
  import regfile_sb_pkg::*;
#(
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter int unsigned ADDR_W  = DEF_ADDR_W,
  parameter int unsigned NREAD   = 2,
  parameter int unsigned BYPASS  = 1,
  parameter int unsigned ZERO_R0 = 1
) (
  input logic         clk,
  input logic         reset,
  regfile_sb_if.slave bus
);

  localparam int unsigned DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  reg_state_e        st_q  [DEPTH];
  reg_state_e        st_d  [DEPTH];

  logic [DEPTH-1:0]  pend_vec;
  reg_idx_t          waddr_x;
  reg_idx_t          alloc_x;
  logic              wr_eff;
  logic              alloc_ok;
  logic              alloc_set;

  logic [DATA_W-1:0] rd_w [NREAD];
  logic              rv_w [NREAD];

  assign waddr_x = reg_idx_t'(bus.waddr);
  assign alloc_x = reg_idx_t'(bus.alloc_addr);

  // Write and allocation qualifiers; r0 writes/allocs are accepted but inert.
  always_comb begin
    wr_eff    = bus.we & ~((ZERO_R0 != 0) & is_r0(waddr_x));
    alloc_ok  = bus.alloc_en &
                (~pend_vec[bus.alloc_addr] | (bus.we & (waddr_x == alloc_x)));
    alloc_set = alloc_ok & ~((ZERO_R0 != 0) & is_r0(alloc_x));
  end

  // Next data and scoreboard state; an accepted alloc outranks the write clear.
  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
      st_d[i]  = st_q[i];
      if (wr_eff && (waddr_x == reg_idx_t'(i))) begin
        mem_d[i] = bus.wdata;
      end
      case (st_q[i])
        FREE: begin
          if (alloc_set && (alloc_x == reg_idx_t'(i))) st_d[i] = PEND;
        end
        PEND: begin
          if (alloc_set && (alloc_x == reg_idx_t'(i))) st_d[i] = PEND;
          else if (wr_eff && (waddr_x == reg_idx_t'(i))) st_d[i] = FREE;
        end
        default: st_d[i] = FREE;
      endcase
    end
  end

  // Data array and scoreboard registers with asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
        st_q[i]  <= FREE;
      end
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
        st_q[i]  <= st_d[i];
      end
    end
  end

  // Flatten scoreboard states into the pending vector.
  always_comb begin
    pend_vec = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      pend_vec[i] = (st_q[i] == PEND);
    end
  end

  for (genvar k = 0; k < NREAD; k++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    assign ra = bus.raddr[k*ADDR_W +: ADDR_W];

    regfile_sb_read #(
      .DATA_W  (DATA_W),
      .ADDR_W  (ADDR_W),
      .BYPASS  (BYPASS),
      .ZERO_R0 (ZERO_R0)
    ) u_rd (
      .raddr_i       (ra),
      .stored_i      (mem_q[ra]),
      .stored_pend_i (pend_vec[ra]),
      .wr_en_i       (wr_eff),
      .waddr_i       (bus.waddr),
      .wdata_i       (bus.wdata),
      .rdata_o       (rd_w[k]),
      .rvalid_o      (rv_w[k])
    );
  end

  // Pack per-port results onto the bus.
  always_comb begin
    bus.rdata  = '0;
    bus.rvalid = '0;
    for (int unsigned k = 0; k < NREAD; k++) begin
      bus.rdata[k*DATA_W +: DATA_W] = rd_w[k];
      bus.rvalid[k]                 = rv_w[k];
    end
  end

  assign bus.alloc_ok = alloc_ok;
  assign bus.pending  = pend_vec;

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench: one bypassing and one non-bypassing register file
// driven with identical stimulus and compared against a behavioural model.
module tb_regfile_sb;

  localparam int unsigned DW    = 16;
  localparam int unsigned AW    = 4;
  localparam int unsigned NR    = 4;
  localparam int unsigned DEPTH = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  regfile_sb_if #(.DATA_W(DW), .ADDR_W(AW), .NREAD(NR)) bus_b ();
  regfile_sb_if #(.DATA_W(DW), .ADDR_W(AW), .NREAD(NR)) bus_n ();

  regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .NREAD(NR), .BYPASS(1), .ZERO_R0(1))
    dut_b (.clk(clk), .reset(reset), .bus(bus_b.slave));
  regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .NREAD(NR), .BYPASS(0), .ZERO_R0(1))
    dut_n (.clk(clk), .reset(reset), .bus(bus_n.slave));

  assign bus_n.we         = bus_b.we;
  assign bus_n.waddr      = bus_b.waddr;
  assign bus_n.wdata      = bus_b.wdata;
  assign bus_n.raddr      = bus_b.raddr;
  assign bus_n.alloc_en   = bus_b.alloc_en;
  assign bus_n.alloc_addr = bus_b.alloc_addr;

  // Reference model: architectural contents and outstanding multi-cycle ops.
  logic [DW-1:0] m_mem  [DEPTH];
  bit            m_pend [DEPTH];

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] exp_rdata(input bit byp, input logic [AW-1:0] ra);
    if (ra == 0) return '0;
    if (byp && bus_b.we && bus_b.waddr == ra) return bus_b.wdata;
    return m_mem[ra];
  endfunction

  function automatic logic exp_rvalid(input bit byp, input logic [AW-1:0] ra);
    if (ra == 0) return 1'b1;
    if (byp && bus_b.we && bus_b.waddr == ra) return 1'b1;
    return !m_pend[ra];
  endfunction

  function automatic logic exp_aok();
    return bus_b.alloc_en &&
           (!m_pend[bus_b.alloc_addr] || (bus_b.we && bus_b.waddr == bus_b.alloc_addr));
  endfunction

  function automatic logic [DEPTH-1:0] exp_pend();
    logic [DEPTH-1:0] pv;
    for (int i = 0; i < DEPTH; i++) pv[i] = m_pend[i];
    return pv;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) begin
      m_mem[i]  = '0;
      m_pend[i] = 1'b0;
    end
  endtask

  // Apply the edge's effect: write clears, accepted alloc sets afterwards.
  task automatic model_commit();
    logic aok;
    aok = exp_aok();
    if (bus_b.we && bus_b.waddr != 0) begin
      m_mem[bus_b.waddr]  = bus_b.wdata;
      m_pend[bus_b.waddr] = 1'b0;
    end
    if (aok && bus_b.alloc_addr != 0) m_pend[bus_b.alloc_addr] = 1'b1;
  endtask

  task automatic check_all(input string tag);
    logic [AW-1:0] ra;
    for (int k = 0; k < NR; k++) begin
      ra = bus_b.raddr[k*AW +: AW];
      chk($sformatf("%s rdata%0d byp", tag, k), 32'(bus_b.rdata[k*DW +: DW]), 32'(exp_rdata(1'b1, ra)));
      chk($sformatf("%s rvalid%0d byp", tag, k), 32'(bus_b.rvalid[k]), 32'(exp_rvalid(1'b1, ra)));
      chk($sformatf("%s rdata%0d nobyp", tag, k), 32'(bus_n.rdata[k*DW +: DW]), 32'(exp_rdata(1'b0, ra)));
      chk($sformatf("%s rvalid%0d nobyp", tag, k), 32'(bus_n.rvalid[k]), 32'(exp_rvalid(1'b0, ra)));
    end
    chk($sformatf("%s alloc_ok byp", tag), 32'(bus_b.alloc_ok), 32'(exp_aok()));
    chk($sformatf("%s alloc_ok nobyp", tag), 32'(bus_n.alloc_ok), 32'(exp_aok()));
    chk($sformatf("%s pending byp", tag), 32'(bus_b.pending), 32'(exp_pend()));
    chk($sformatf("%s pending nobyp", tag), 32'(bus_n.pending), 32'(exp_pend()));
  endtask

  task automatic idle_inputs();
    bus_b.we         = 1'b0;
    bus_b.waddr      = '0;
    bus_b.wdata      = '0;
    bus_b.raddr      = '0;
    bus_b.alloc_en   = 1'b0;
    bus_b.alloc_addr = '0;
  endtask

  typedef struct {
    logic          we;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic [AW-1:0] ra0;
    logic [AW-1:0] ra1;
    logic          ae;
    logic [AW-1:0] aa;
    logic [DW-1:0] rd0;
    logic          rv0;
    logic [DW-1:0] rd1b;
    logic          rv1b;
    logic [DW-1:0] rd1n;
    logic          rv1n;
    logic          aok;
  } vec_t;

  vec_t tbl [15];

  initial begin
    //             we    wa     wd         ra0    ra1    ae    aa     rd0        rv0   rd1b       rv1b  rd1n       rv1n  aok
    tbl[0]  = '{1'b1, 4'd3, 16'h1234, 4'd3, 4'd3, 1'b0, 4'd0, 16'h1234, 1'b1, 16'h1234, 1'b1, 16'h0000, 1'b1, 1'b0};
    tbl[1]  = '{1'b0, 4'd0, 16'h0000, 4'd3, 4'd0, 1'b0, 4'd0, 16'h1234, 1'b1, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};
    tbl[2]  = '{1'b1, 4'd0, 16'hFFFF, 4'd0, 4'd0, 1'b0, 4'd0, 16'h0000, 1'b1, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};
    tbl[3]  = '{1'b0, 4'd0, 16'h0000, 4'd0, 4'd3, 1'b0, 4'd0, 16'h0000, 1'b1, 16'h1234, 1'b1, 16'h1234, 1'b1, 1'b0};
    tbl[4]  = '{1'b1, 4'd5, 16'hA5A5, 4'd3, 4'd5, 1'b0, 4'd0, 16'h1234, 1'b1, 16'hA5A5, 1'b1, 16'h0000, 1'b1, 1'b0};
    tbl[5]  = '{1'b0, 4'd0, 16'h0000, 4'd5, 4'd2, 1'b1, 4'd2, 16'hA5A5, 1'b1, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b1};
    tbl[6]  = '{1'b0, 4'd0, 16'h0000, 4'd2, 4'd2, 1'b1, 4'd2, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0};
    tbl[7]  = '{1'b1, 4'd2, 16'h0042, 4'd2, 4'd2, 1'b0, 4'd0, 16'h0042, 1'b1, 16'h0042, 1'b1, 16'h0000, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 4'd0, 16'h0000, 4'd2, 4'd2, 1'b0, 4'd0, 16'h0042, 1'b1, 16'h0042, 1'b1, 16'h0042, 1'b1, 1'b0};
    tbl[9]  = '{1'b0, 4'd0, 16'h0000, 4'd4, 4'd4, 1'b1, 4'd4, 16'h0000, 1'b1, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b1};
    tbl[10] = '{1'b1, 4'd4, 16'hBEEF, 4'd4, 4'd4, 1'b1, 4'd4, 16'hBEEF, 1'b1, 16'hBEEF, 1'b1, 16'h0000, 1'b0, 1'b1};
    tbl[11] = '{1'b0, 4'd0, 16'h0000, 4'd4, 4'd4, 1'b0, 4'd0, 16'hBEEF, 1'b0, 16'hBEEF, 1'b0, 16'hBEEF, 1'b0, 1'b0};
    tbl[12] = '{1'b0, 4'd0, 16'h0000, 4'd0, 4'd4, 1'b1, 4'd0, 16'h0000, 1'b1, 16'hBEEF, 1'b0, 16'hBEEF, 1'b0, 1'b1};
    tbl[13] = '{1'b1, 4'd7, 16'h7777, 4'd7, 4'd6, 1'b1, 4'd6, 16'h7777, 1'b1, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b1};
    tbl[14] = '{1'b0, 4'd0, 16'h0000, 4'd7, 4'd6, 1'b0, 4'd0, 16'h7777, 1'b1, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0};

    idle_inputs();
    model_clear();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    check_all("reset");
    @(posedge clk);
    #1;

    // Directed vectors; ports 2/3 mirror ports 0/1 to exercise shared addresses.
    for (int v = 0; v < 15; v++) begin
      bus_b.we         = tbl[v].we;
      bus_b.waddr      = tbl[v].wa;
      bus_b.wdata      = tbl[v].wd;
      bus_b.raddr      = {tbl[v].ra1, tbl[v].ra0, tbl[v].ra1, tbl[v].ra0};
      bus_b.alloc_en   = tbl[v].ae;
      bus_b.alloc_addr = tbl[v].aa;
      #2;
      for (int k = 0; k < NR; k += 2) begin
        chk($sformatf("vec%0d rdata%0d", v, k), 32'(bus_b.rdata[k*DW +: DW]), 32'(tbl[v].rd0));
        chk($sformatf("vec%0d rvalid%0d", v, k), 32'(bus_b.rvalid[k]), 32'(tbl[v].rv0));
        chk($sformatf("vec%0d rdata%0d byp", v, k+1), 32'(bus_b.rdata[(k+1)*DW +: DW]), 32'(tbl[v].rd1b));
        chk($sformatf("vec%0d rvalid%0d byp", v, k+1), 32'(bus_b.rvalid[k+1]), 32'(tbl[v].rv1b));
        chk($sformatf("vec%0d rdata%0d nobyp", v, k+1), 32'(bus_n.rdata[(k+1)*DW +: DW]), 32'(tbl[v].rd1n));
        chk($sformatf("vec%0d rvalid%0d nobyp", v, k+1), 32'(bus_n.rvalid[k+1]), 32'(tbl[v].rv1n));
      end
      chk($sformatf("vec%0d alloc_ok", v), 32'(bus_b.alloc_ok), 32'(tbl[v].aok));
      check_all($sformatf("vec%0d", v));
      @(posedge clk);
      model_commit();
      #1;
    end
    chk("r6 pending before reset", 32'(bus_b.pending[6]), 32'd1);

    // Asynchronous reset between edges clears everything immediately.
    idle_inputs();
    bus_b.raddr = {4'd7, 4'd6, 4'd4, 4'd2};
    #1 reset = 1'b1;
    #1;
    chk("async rst pending byp", 32'(bus_b.pending), 32'd0);
    chk("async rst pending nobyp", 32'(bus_n.pending), 32'd0);
    chk("async rst rdata byp", 32'(bus_b.rdata), 32'd0);
    chk("async rst rdata nobyp", 32'(bus_n.rdata), 32'd0);
    chk("async rst rvalid", 32'(bus_b.rvalid), 32'hF);

    // Writes and allocations held across an edge during reset are ignored.
    bus_b.we = 1'b1; bus_b.waddr = 4'd5; bus_b.wdata = 16'h1111;
    bus_b.alloc_en = 1'b1; bus_b.alloc_addr = 4'd9;
    @(posedge clk);
    #1;
    idle_inputs();
    bus_b.raddr = {4'd9, 4'd5, 4'd9, 4'd5};
    #1;
    chk("rst hold pending", 32'(bus_b.pending), 32'd0);
    chk("rst hold rdata", 32'(bus_b.rdata), 32'd0);
    reset = 1'b0;
    model_clear();
    #1;

    // After reset every address reads zero and is valid.
    for (int a = 0; a < DEPTH; a++) begin
      bus_b.raddr = {4'(a), 4'(a), 4'(a), 4'(a)};
      #1;
      check_all($sformatf("post rst a%0d", a));
    end
    bus_b.alloc_en = 1'b1;
    bus_b.alloc_addr = 4'd11;
    #1;
    chk("post rst alloc_ok", 32'(bus_b.alloc_ok), 32'd1);
    bus_b.alloc_en = 1'b0;
    @(posedge clk);
    #1;

    // Randomised traffic against the model.
    for (int c = 0; c < 600; c++) begin
      logic [AW-1:0] ra [NR];
      bus_b.we         = 1'($urandom_range(0, 1));
      bus_b.waddr      = 4'($urandom_range(0, DEPTH - 1));
      bus_b.wdata      = 16'($urandom);
      bus_b.alloc_en   = ($urandom_range(0, 2) == 0);
      bus_b.alloc_addr = ($urandom_range(0, 3) == 0) ? bus_b.waddr : 4'($urandom_range(0, DEPTH - 1));
      for (int k = 0; k < NR; k++) begin
        ra[k] = ($urandom_range(0, 3) == 0) ? bus_b.waddr : 4'($urandom_range(0, DEPTH - 1));
      end
      bus_b.raddr = {ra[3], ra[2], ra[1], ra[0]};
      #2;
      check_all($sformatf("rnd%0d", c));
      @(posedge clk);
      model_commit();
      #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 Parameter DATA_W, default 16, register data width in bits.
REQ-002 Parameter ADDR_W, default 3, register address width; depth = 2**ADDR_W.
REQ-003 Parameter NREAD, default 2, number of independent read ports (1..4).
REQ-004 Parameter BYPASS, default 1; 1 = same-cycle write-to-read forwarding, 0 = none.
REQ-005 Parameter ZERO_R0, default 1; 1 = register 0 reads zero and is never pending.
REQ-006 clk  in  1  single clock; all state updates on the rising edge.
REQ-007 reset  in  1  asynchronous, active-high reset.
REQ-008 we  in  1  write enable for the write port.
REQ-009 waddr  in  ADDR_W  write destination register.
REQ-010 wdata  in  DATA_W  write data.
REQ-011 raddr  in  NREAD x ADDR_W  read addresses, packed, port 0 in the LSBs.
REQ-012 rdata  out  NREAD x DATA_W  combinational read data, packed the same way.
REQ-013 rvalid  out  NREAD  1 = rdata[i] holds a committed or bypassed value (register not pending).
REQ-014 alloc_en  in  1  request to mark a destination register pending (multi-cycle op issue).
REQ-015 alloc_addr  in  ADDR_W  register to allocate.
REQ-016 alloc_ok  out  1  combinational; 1 = the allocation is accepted this cycle.
REQ-017 pending  out  2**ADDR_W  scoreboard bit vector, registered.

Function
REQ-018 A write with we=1 updates register waddr at the clock edge and clears pending[waddr].
REQ-019 With ZERO_R0=1, a write to register 0 is discarded, rdata for raddr=0 is 0, rvalid is 1, and pending[0] stays 0.
REQ-020 Reads are combinational; each port is independent; any number of ports may read the same address.
REQ-021 With BYPASS=1 and we=1, waddr=raddr[i] (not a discarded r0 write): rdata[i]=wdata and rvalid[i]=1 in the same cycle.
REQ-022 Otherwise rdata[i] is the stored value and rvalid[i] = ~pending[raddr[i]].
REQ-023 alloc_ok = alloc_en & (~pending[alloc_addr] | (we & waddr==alloc_addr)); with ZERO_R0=1, alloc of r0 yields alloc_ok=1 with no state change.
REQ-024 An accepted allocation sets pending[alloc_addr] at the clock edge; a rejected one changes nothing.
REQ-025 Simultaneous write and accepted allocation of the same register: data is written, pending ends at 1 (set wins over clear).
REQ-026 Simultaneous write and allocation of different registers: both take effect independently.
REQ-027 A write to a non-pending register is legal and only updates data.
REQ-028 Per-register state machine: FREE -> PEND on accepted alloc; PEND -> FREE on write without same-register alloc; PEND -> PEND on write plus alloc; no other transitions.
REQ-029 All address arithmetic is unsigned ADDR_W bits; no wrap-around or out-of-range case exists.

Reset
REQ-030 While reset=1 all registers read 0, all pending bits are 0, and writes and allocations are ignored.
REQ-031 Reset asserted mid-operation clears all state immediately, without waiting for a clock edge.
REQ-032 After reset deassertion: rdata=0 and rvalid all 1 for every address; alloc_ok follows alloc_en.

Structure
REQ-033 The default widths (DATA_W=16, ADDR_W=3) and a register-index type belong in the shared processor package, and the top level uses them.
REQ-034 One sub-module, regfile_sb_read, implements one read port (bypass mux, zero mux, rvalid) and is instantiated NREAD times via generate.
REQ-035 The data array and the scoreboard are held in regfile_sb itself and are not split into further modules.

Verification
REQ-036 Reset, then write r3=0x1234 -> next cycle raddr0=3 gives rdata=0x1234, rvalid=1.
REQ-037 Write r0=0xFFFF -> rdata=0 for raddr=0; pending[0]=0.
REQ-038 BYPASS=1: we=1, waddr=5, wdata=0xA5A5, raddr1=5 in the same cycle -> rdata1=0xA5A5 combinationally. BYPASS=0, same stimulus -> rdata1 shows the old value.
REQ-039 Alloc r2 -> pending[2]=1 and reading r2 gives rvalid=0. A second alloc of r2 -> alloc_ok=0. Write r2=0x0042 -> pending[2]=0, rvalid=1, data=0x0042.
REQ-040 Alloc r4 while pending, in the same cycle as a write to r4 -> alloc_ok=1, data updated, pending[4] stays 1.
REQ-041 Pending r6, assert reset between clock edges -> pending=0 and all rdata=0 before the next edge.
REQ-042 The bench runs with NREAD=4 and ADDR_W=4, randomises reads against a reference model, and checks all ports.
